// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared display-code constants and active-low glyph patterns
//               for the multiplexed 7-segment scan driver. Glyph bytes are
//               ordered {a,b,c,d,e,f,g,dp}; a 0 bit lights the segment.
// Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // 5-bit display codes
    localparam logic [4:0] CODE_HEX_MIN = 5'h00;
    localparam logic [4:0] CODE_HEX_MAX = 5'h0F;
    localparam logic [4:0] CODE_MINUS   = 5'h10;
    localparam logic [4:0] CODE_BLANK   = 5'h1F;

    // Bit position of the decimal point within a glyph byte
    localparam int DP_BIT = 0;

    // Hex glyphs 0-9, A, b, c, d, E, F (dp off)
    localparam logic [7:0] GLYPH_HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'hE5, 8'h85, 8'h61, 8'h71
    };
    localparam logic [7:0] GLYPH_MINUS = 8'hFD;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode
// Description : Combinational glyph lookup for one digit, with decimal-point
//               and blanking applied on top of the glyph.
//   i_code    : 5-bit display code (hex, minus, or blank range)
//   i_enable  : 0 forces the whole digit dark, dp included
//   i_dot     : 1 lights the decimal point of an enabled digit
//   o_pattern : active-low segments {a,b,c,d,e,f,g,dp}
// Revision    : 1.0  initial release
// ============================================================================
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] i_code,
    input  logic       i_enable,
    input  logic       i_dot,
    output logic [7:0] o_pattern
);

    logic [7:0] w_glyph;

    always_comb begin
        // Everything above CODE_MINUS, CODE_BLANK included, renders dark
        if (i_code <= CODE_HEX_MAX) begin
            w_glyph = GLYPH_HEX[i_code[3:0]];
        end else if (i_code == CODE_MINUS) begin
            w_glyph = GLYPH_MINUS;
        end else begin
            w_glyph = GLYPH_BLANK;
        end
    end

    always_comb begin
        o_pattern = w_glyph;
        if (!i_enable) begin
            o_pattern = GLYPH_BLANK;
        end else if (i_dot) begin
            o_pattern[DP_BIT] = 1'b0;
        end
    end

endmodule : seg_decode
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed 7-segment scan driver with double-buffered
//               display data, per-digit blanking, decimal point and blink.
//   CLK, RST  : single clock, synchronous active-high reset
//   DIGITS    : 5-bit code per digit, digit i at [5i+4:5i], digit 0 rightmost
//   EN/DOT/BLINK : per-digit enable, decimal point, blink enable
//   LOAD      : one-cycle strobe capturing DIGITS/EN/DOT/BLINK
//   SEG_OUT   : registered active-low segments {a,b,c,d,e,f,g,dp}
//   DIG_SEL   : registered active-low digit select, one guard cycle per slot
//   FRAME_END : pulse on the last cycle of the last digit slot
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [5*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   EN,
    input  logic [NUM_DIGITS-1:0]   DOT,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    input  logic                    LOAD,
    output logic [7:0]              SEG_OUT,
    output logic [NUM_DIGITS-1:0]   DIG_SEL,
    output logic                    FRAME_END
);

    localparam int c_PRESC_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_FCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_DATA_W  = 8 * NUM_DIGITS;

    // Field layout of one display-data word: {DIGITS, EN, DOT, BLINK}
    localparam int c_BLINK_LSB = 0;
    localparam int c_DOT_LSB   = NUM_DIGITS;
    localparam int c_EN_LSB    = 2 * NUM_DIGITS;
    localparam int c_CODE_LSB  = 3 * NUM_DIGITS;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_FCNT_W-1:0]  c_FCNT_LAST  = c_FCNT_W'(BLINK_FRAMES - 1);

    // State
    logic [c_PRESC_W-1:0]  r_presc_q,    w_presc_d;
    logic [c_IDX_W-1:0]    r_idx_q,      w_idx_d;
    logic [c_FCNT_W-1:0]   r_fcnt_q,     w_fcnt_d;
    logic                  r_blink_q,    w_blink_d;
    logic [c_DATA_W-1:0]   r_pend_q,     w_pend_d;
    logic                  r_pend_vld_q, w_pend_vld_d;
    logic [c_DATA_W-1:0]   r_act_q,      w_act_d;
    logic [7:0]            r_seg_out_q,  w_seg_out_d;
    logic [NUM_DIGITS-1:0] r_dig_sel_q,  w_dig_sel_d;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [c_DATA_W-1:0]   w_in;

    logic [4:0]            w_codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_act_en;
    logic [NUM_DIGITS-1:0] w_act_dot;
    logic [NUM_DIGITS-1:0] w_act_blink;
    logic [4:0]            w_code;
    logic                  w_dot;
    logic                  w_dec_en;
    logic [7:0]            w_pattern;

    // ------------------------------------------------------------------
    // Scan timing: prescaler, digit index, frame counter, blink phase
    // ------------------------------------------------------------------
    always_comb begin
        w_tick      = (r_presc_q == c_PRESC_LAST);
        w_frame_end = w_tick && (r_idx_q == c_IDX_LAST);

        w_presc_d = w_tick ? '0 : r_presc_q + c_PRESC_W'(1);

        w_idx_d = r_idx_q;
        if (w_tick) begin
            w_idx_d = (r_idx_q == c_IDX_LAST) ? '0 : r_idx_q + c_IDX_W'(1);
        end

        w_fcnt_d  = r_fcnt_q;
        w_blink_d = r_blink_q;
        if (w_frame_end) begin
            if (r_fcnt_q == c_FCNT_LAST) begin
                w_fcnt_d  = '0;
                w_blink_d = ~r_blink_q;
            end else begin
                w_fcnt_d = r_fcnt_q + c_FCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A LOAD landing on the frame boundary bypasses the
    // pending stage so it shows from the very next frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_in         = {DIGITS, EN, DOT, BLINK};
        w_pend_d     = r_pend_q;
        w_pend_vld_d = r_pend_vld_q;
        w_act_d      = r_act_q;
        if (LOAD && w_frame_end) begin
            w_act_d      = w_in;
            w_pend_vld_d = 1'b0;
        end else if (LOAD) begin
            w_pend_d     = w_in;
            w_pend_vld_d = 1'b1;
        end else if (w_frame_end && r_pend_vld_q) begin
            w_act_d      = r_pend_q;
            w_pend_vld_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Digit mux. The outputs are registered, so they are computed from the
    // next-state index, data and blink phase: the pattern is then already
    // valid in the guard cycle that opens each slot.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_codes
        assign w_codes[gi] = w_act_d[c_CODE_LSB + 5*gi +: 5];
    end

    assign w_act_en    = w_act_d[c_EN_LSB    +: NUM_DIGITS];
    assign w_act_dot   = w_act_d[c_DOT_LSB   +: NUM_DIGITS];
    assign w_act_blink = w_act_d[c_BLINK_LSB +: NUM_DIGITS];

    always_comb begin
        w_code   = w_codes[w_idx_d];
        w_dot    = w_act_dot[w_idx_d];
        w_dec_en = w_act_en[w_idx_d] & ~(w_act_blink[w_idx_d] & w_blink_d);

        // Guard cycle at prescaler 0: no digit selected while segments settle
        w_dig_sel_d = '1;
        if (w_presc_d != '0) begin
            w_dig_sel_d[w_idx_d] = 1'b0;
        end
    end

    seg_decode u_seg_decode (
        .i_code    (w_code),
        .i_enable  (w_dec_en),
        .i_dot     (w_dot),
        .o_pattern (w_pattern)
    );

    assign w_seg_out_d = w_pattern;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc_q    <= '0;
            r_idx_q      <= '0;
            r_fcnt_q     <= '0;
            r_blink_q    <= 1'b0;
            r_pend_q     <= '0;
            r_pend_vld_q <= 1'b0;
            r_act_q      <= '0;
            r_seg_out_q  <= GLYPH_BLANK;
            r_dig_sel_q  <= '1;
        end else begin
            r_presc_q    <= w_presc_d;
            r_idx_q      <= w_idx_d;
            r_fcnt_q     <= w_fcnt_d;
            r_blink_q    <= w_blink_d;
            r_pend_q     <= w_pend_d;
            r_pend_vld_q <= w_pend_vld_d;
            r_act_q      <= w_act_d;
            r_seg_out_q  <= w_seg_out_d;
            r_dig_sel_q  <= w_dig_sel_d;
        end
    end

    assign SEG_OUT   = r_seg_out_q;
    assign DIG_SEL   = r_dig_sel_q;
    assign FRAME_END = w_frame_end;

endmodule : seg_scan_driver
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver (4 digits, 4 clocks
//               per slot, 2 frames per blink half-period). Expected outputs
//               come from a time-based reference: position in the scan is
//               derived from the cycle count since reset, the data shown in
//               a frame is the last LOAD issued before that frame began, and
//               glyphs are built from lists of lit segment letters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BF  = 2;
    localparam int F   = N * DIV;

    typedef struct packed {
        logic [5*N-1:0] digits;
        logic [N-1:0]   en;
        logic [N-1:0]   dot;
        logic [N-1:0]   blink;
    } data_t;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [5*N-1:0] DIGITS = '0;
    logic [N-1:0]   EN = '0;
    logic [N-1:0]   DOT = '0;
    logic [N-1:0]   BLINK = '0;
    logic           LOAD = 1'b0;
    logic [7:0]     SEG_OUT;
    logic [N-1:0]   DIG_SEL;
    logic           FRAME_END;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIGITS    (DIGITS),
        .EN        (EN),
        .DOT       (DOT),
        .BLINK     (BLINK),
        .LOAD      (LOAD),
        .SEG_OUT   (SEG_OUT),
        .DIG_SEL   (DIG_SEL),
        .FRAME_END (FRAME_END)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    int    t = 0;
    data_t m_act = '0;
    data_t m_pend = '0;
    bit    m_pend_vld = 1'b0;
    int    m_pend_frame = 0;

    int errors = 0;
    int checks = 0;

    // Lit segments for hex glyphs 0..F
    string hex_lit [16] = '{
        "abcdef", "bc",     "abdeg",  "abcdg",
        "bcfg",   "acdfg",  "acdefg", "abc",
        "abcdefg","abcdfg", "abcefg", "cdefg",
        "deg",    "bcdeg",  "adefg",  "aefg"
    };

    function automatic logic [7:0] segs_from_letters(string s);
        logic [7:0] p;
        p = 8'hFF;
        for (int i = 0; i < s.len(); i++) begin
            int k;
            k = int'(s[i]) - 97;
            p[7 - k] = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_glyph(int code);
        if (code < 16)  return segs_from_letters(hex_lit[code]);
        if (code == 16) return segs_from_letters("g");
        return 8'hFF;
    endfunction

    function automatic logic [7:0] ref_digit(data_t d, int idx, bit phase);
        int         code;
        bit         en, dot, blk;
        logic [7:0] p;
        code = int'(5'(d.digits >> (5 * idx)));
        en   = ((d.en    >> idx) & 4'd1) != 4'd0;
        dot  = ((d.dot   >> idx) & 4'd1) != 4'd0;
        blk  = ((d.blink >> idx) & 4'd1) != 4'd0;
        if (!en || (blk && phase)) return 8'hFF;
        p = ref_glyph(code);
        if (dot) p = p & 8'hFE;
        return p;
    endfunction

    function automatic data_t mk(logic [5*N-1:0] digits, logic [N-1:0] en,
                                 logic [N-1:0] dot, logic [N-1:0] blink);
        data_t d;
        d.digits = digits;
        d.en     = en;
        d.dot    = dot;
        d.blink  = blink;
        return d;
    endfunction

    function automatic data_t rand_data();
        return mk(20'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endfunction

    task automatic check();
        int         presc, idx, f;
        bit         phase;
        logic [7:0] exp_seg;
        logic [N-1:0] exp_sel;
        logic       exp_fe;
        presc   = t % DIV;
        idx     = (t / DIV) % N;
        f       = t / F;
        phase   = ((f / BF) % 2) == 1;
        exp_sel = (presc == 0) ? 4'hF : ~(4'b0001 << idx);
        exp_fe  = (presc == DIV - 1) && (idx == N - 1);
        exp_seg = ref_digit(m_act, idx, phase);

        checks++;
        assert (SEG_OUT === exp_seg) else begin
            errors++;
            $error("FAIL seg_out t=%0d observed=%h expected=%h", t, SEG_OUT, exp_seg);
        end
        checks++;
        assert (DIG_SEL === exp_sel) else begin
            errors++;
            $error("FAIL dig_sel t=%0d observed=%b expected=%b", t, DIG_SEL, exp_sel);
        end
        checks++;
        assert (FRAME_END === exp_fe) else begin
            errors++;
            $error("FAIL frame_end t=%0d observed=%b expected=%b", t, FRAME_END, exp_fe);
        end
    endtask

    // One clock: update the reference with what the DUT sampled, then check.
    task automatic step();
        @(posedge CLK);
        if (RST) begin
            t          = 0;
            m_act      = '0;
            m_pend     = '0;
            m_pend_vld = 1'b0;
        end else begin
            if (LOAD) begin
                m_pend       = mk(DIGITS, EN, DOT, BLINK);
                m_pend_vld   = 1'b1;
                m_pend_frame = t / F;
            end
            t++;
            if (m_pend_vld && (m_pend_frame < t / F)) begin
                m_act      = m_pend;
                m_pend_vld = 1'b0;
            end
        end
        #1;
        check();
    endtask

    // Idle cycles with data inputs scrambled; they must not leak through.
    task automatic idle(int n);
        data_t d;
        for (int i = 0; i < n; i++) begin
            d      = rand_data();
            DIGITS = d.digits;
            EN     = d.en;
            DOT    = d.dot;
            BLINK  = d.blink;
            LOAD   = 1'b0;
            step();
        end
    endtask

    task automatic do_load(data_t d);
        DIGITS = d.digits;
        EN     = d.en;
        DOT    = d.dot;
        BLINK  = d.blink;
        LOAD   = 1'b1;
        step();
        LOAD   = 1'b0;
    endtask

    // Advance until the current cycle is position k within the frame.
    task automatic align_to(int k);
        for (int i = 0; i < F && (t % F) != k; i++) idle(1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stimulus
        data_t x, y;

        // Reset, then free-running scan of blank digits
        RST  = 1'b1;
        LOAD = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        idle(40);

        // Decode: minus, A, 3 with dot, 0
        align_to(6);
        do_load(mk({5'h10, 5'h0A, 5'h03, 5'h00}, 4'hF, 4'b0010, 4'b0000));
        idle(2 * F);

        // Buffering: X then Y two cycles later, only Y ever shows
        align_to(3);
        x = mk({5'h01, 5'h02, 5'h04, 5'h05}, 4'hF, 4'b0101, 4'b0000);
        y = mk({5'h0E, 5'h0F, 5'h06, 5'h09}, 4'hF, 4'b1000, 4'b0000);
        do_load(x);
        idle(1);
        do_load(y);
        idle(2 * F);

        // Coincident load on the FRAME_END cycle
        align_to(F - 1);
        do_load(mk({5'h07, 5'h0B, 5'h0C, 5'h0D}, 4'hF, 4'b0000, 4'b0000));
        idle(F + 4);

        // Blink on digit 0 only
        align_to(2);
        do_load(mk({5'h05, 5'h04, 5'h02, 5'h08}, 4'hF, 4'b0000, 4'b0001));
        idle(9 * F);

        // Random loads at random times
        for (int i = 0; i < 25; i++) begin
            idle(int'($urandom_range(0, 20)));
            do_load(rand_data());
        end
        idle(2 * F);

        // Mid-frame reset during the digit 2 slot, with LOAD held high
        align_to(9);
        do_load(mk({5'h08, 5'h08, 5'h08, 5'h08}, 4'hF, 4'hF, 4'h0));
        RST  = 1'b1;
        LOAD = 1'b1;
        step();
        step();
        RST  = 1'b0;
        LOAD = 1'b0;
        idle(2 * F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seg_scan_driver
`default_nettype wire
